// File: rtl/seq_gain_multiplier_if.sv
// rtl/seq_gain_multiplier_if.sv - operand/result handshake bundle for the sequential gain multiplier
interface seq_gain_multiplier_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] sample_in;
  logic [COEF_W-1:0] gain_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result_out;
  logic              saturated;
  logic              busy;

  modport master (
    output in_valid, sample_in, gain_in, out_ready,
    input  in_ready, out_valid, result_out, saturated, busy
  );

  modport slave (
    input  in_valid, sample_in, gain_in, out_ready,
    output in_ready, out_valid, result_out, saturated, busy
  );
endinterface

// File: rtl/seq_gain_multiplier.sv
// rtl/seq_gain_multiplier.sv - shift-add multiplier applying an unsigned fixed-point gain to a signed sample
// One gain bit per clock, round half toward +inf, saturate to DATA_W; zero operands bypass the loop.
module seq_gain_multiplier #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_gain_multiplier_if.slave  bus
);
  localparam int ACC_W = DATA_W + COEF_W + 1;
  localparam int CNT_W = $clog2(COEF_W + 1);
  localparam logic [CNT_W-1:0]        LAST_BIT = CNT_W'(COEF_W - 1);
  localparam logic signed [ACC_W-1:0] RND_HALF = (ACC_W'(1) << FRAC_BITS) >> 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_ROUND, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic signed [ACC_W-1:0]  r_acc, r_mcand;
  logic [COEF_W-1:0]        r_gain;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_W-1:0]        r_result;
  logic                     r_sat;
  logic signed [ACC_W-1:0]  w_sum, w_shift;
  logic                     w_xfer, w_zero, w_hi, w_lo;
  logic                     w_in_ready, w_out_valid, w_busy;

  assign w_xfer  = bus.in_valid && w_in_ready;
  assign w_zero  = (bus.sample_in == '0) || (bus.gain_in == '0);
  assign w_sum   = r_acc + RND_HALF;
  assign w_shift = w_sum >>> FRAC_BITS;
  assign w_hi    = w_shift > SAT_MAX;
  assign w_lo    = w_shift < SAT_MIN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = w_zero ? S_DONE : S_MULT;
      S_MULT:  if (r_cnt == LAST_BIT) w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
      end
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Multiplicand shifts left and gain shifts right each step, so bit 0 always selects the partial product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_gain   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (w_zero) begin
              r_result <= '0;
              r_sat    <= 1'b0;
            end else begin
              r_acc   <= '0;
              r_mcand <= {{(ACC_W-DATA_W){bus.sample_in[DATA_W-1]}}, bus.sample_in};
              r_gain  <= bus.gain_in;
              r_cnt   <= '0;
            end
          end
        end
        S_MULT: begin
          if (r_gain[0]) r_acc <= r_acc + r_mcand;
          r_mcand <= r_mcand <<< 1;
          r_gain  <= r_gain >> 1;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_ROUND: begin
          if (w_hi)      r_result <= {1'b0, {(DATA_W-1){1'b1}}};
          else if (w_lo) r_result <= {1'b1, {(DATA_W-1){1'b0}}};
          else           r_result <= w_shift[DATA_W-1:0];
          r_sat <= w_hi || w_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.busy       = w_busy;
  assign bus.result_out = r_result;
  assign bus.saturated  = r_sat;
endmodule

// File: tb/tb_seq_gain_multiplier.sv
// tb/tb_seq_gain_multiplier.sv - scoreboard bench for seq_gain_multiplier
module tb_seq_gain_multiplier;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int FRAC_BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DATA_W:0] exp_q[$];

  seq_gain_multiplier_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus();

  seq_gain_multiplier #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Real-valued rule: round(sample * gain / 2^F) with halves toward +inf, then clip.
  function automatic logic [DATA_W:0] model(input logic [DATA_W-1:0] s, input logic [COEF_W-1:0] g);
    longint den, num, q, maxv, minv;
    logic [63:0] qv;
    den  = longint'(1) << FRAC_BITS;
    maxv = (longint'(1) << (DATA_W-1)) - 1;
    minv = -(longint'(1) << (DATA_W-1));
    num  = longint'($signed(s)) * longint'(g) + den / 2;
    q    = num / den;
    if ((num % den) != 0 && num < 0) q = q - 1;
    if (q > maxv) return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    if (q < minv) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    qv = q;
    return {1'b0, qv[DATA_W-1:0]};
  endfunction

  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h expected none", bus.result_out);
      end else begin
        e = exp_q.pop_front();
        check("result", bus.result_out, e[DATA_W-1:0]);
        check("saturated", bus.saturated, e[DATA_W]);
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] s, input logic [COEF_W-1:0] g, input int hold);
    int k;
    logic ready_low;
    logic [DATA_W-1:0] held_r;
    logic held_s;
    bus.out_ready = (hold == 0);
    bus.sample_in = s;
    bus.gain_in   = g;
    bus.in_valid  = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_before_xfer", bus.in_ready, 1);
    @(posedge clk);
    exp_q.push_back(model(s, g));
    #1;
    bus.in_valid  = 1'b0;
    bus.sample_in = DATA_W'($urandom);
    bus.gain_in   = COEF_W'($urandom);
    k = 1;
    ready_low = 1'b1;
    while (!bus.out_valid && k < 100) begin
      if (bus.in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, (s == 0 || g == 0) ? 1 : COEF_W + 2);
    check("in_ready_low_while_busy", {ready_low, bus.in_ready}, 2'b10);
    check("busy_in_done", bus.busy, 1);
    if (hold > 0) begin
      held_r = bus.result_out;
      held_s = bus.saturated;
      for (int i = 0; i < hold; i++) begin
        if (i == 0) begin
          bus.in_valid  = 1'b1;
          bus.sample_in = 16'h0101;
          bus.gain_in   = 16'h0202;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_result_stable", bus.result_out, held_r);
        check("bp_sat_stable", bus.saturated, held_s);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_busy", bus.busy, 1);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("in_ready_after_accept", bus.in_ready, 1);
    check("out_valid_after_accept", bus.out_valid, 0);
  endtask

  initial begin
    int k;
    logic [DATA_W-1:0] s;
    logic [COEF_W-1:0] g;
    bus.in_valid  = 1'b0;
    bus.sample_in = '0;
    bus.gain_in   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result_out, 0);
    check("rst_saturated", bus.saturated, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(16'h1000, 16'h0180, 0);
    send(16'hFFFD, 16'h0080, 0);
    send(16'h0003, 16'h0080, 0);
    send(16'h7000, 16'h0200, 0);
    send(16'h8000, 16'h0300, 0);
    send(16'h8000, 16'h0100, 0);
    send(16'hA5C3, 16'h0100, 0);
    send(16'h1234, 16'h0000, 0);
    send(16'h0000, 16'hFFFF, 0);
    send(16'h1234, 16'h0155, 5);

    // Abort an operation part-way through the multiply loop.
    bus.sample_in = 16'h7FFF;
    bus.gain_in   = 16'hFFFF;
    bus.in_valid  = 1'b1;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.result_out, 0);
    check("abort_saturated", bus.saturated, 0);
    check("abort_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(16'h0100, 16'h0100, 0);

    for (int i = 0; i < 40; i++) begin
      s = DATA_W'($urandom);
      g = COEF_W'($urandom);
      if ($urandom_range(0, 7) == 0) s = '0;
      if ($urandom_range(0, 7) == 0) g = '0;
      send(s, g, $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
